uart_cmd_parser: RTL and testbench

UART_CMD_PARSER -- requirements
Module: uart_cmd_parser

---
 rtl/uart_cmd_parser_pkg.sv | 30 +++
 rtl/uart_cmd_parser_ascii_digit_decode.sv | 17 +
 rtl/uart_cmd_parser.sv | 149 ++++++++++++++
 tb/tb_uart_cmd_parser.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_cmd_parser_pkg.sv
// Shared types and constants for the UART "#SS,EE\n" command parser.
// The parser top and the ASCII digit decoder both use these.
package uart_cmd_parser_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SP_T,
        ST_SP_U,
        ST_SEP,
        ST_EP_T,
        ST_EP_U,
        ST_TERM,
        ST_REQ
    } state_t;

    localparam logic [7:0] ASCII_HASH  = 8'h23;
    localparam logic [7:0] ASCII_COMMA = 8'h2C;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_ZERO  = 8'h30;

    localparam int unsigned NODE_W           = 5;
    localparam int unsigned MAX_NODE_DEFAULT = 29;

    // Two decimal digits fit in 7 bits (max 99).
    function automatic logic [6:0] node_value(input logic [3:0] tens, input logic [3:0] units);
        return (7'(tens) * 7'd10) + 7'(units);
    endfunction

endpackage

// File: rtl/uart_cmd_parser_ascii_digit_decode.sv
// Combinational ASCII '0'..'9' classifier and value extractor.
module ascii_digit_decode
    import uart_cmd_parser_pkg::*;
(
    input  logic [7:0] i_byte,
    output logic       o_is_digit,
    output logic [3:0] o_value
);

    logic [7:0] w_off;

    // Bytes below '0' wrap to large values, so a single compare covers both bounds.
    assign w_off      = i_byte - ASCII_ZERO;
    assign o_is_digit = (w_off < 8'd10);
    assign o_value    = w_off[3:0];

endmodule

// File: rtl/uart_cmd_parser.sv
// Parses "#SS,EE\n" frames from a UART byte stream into SP/EP node indices and
// hands them to the path planner with a start_req/start_ack handshake.
module uart_cmd_parser
    import uart_cmd_parser_pkg::*;
#(
    parameter int unsigned MAX_NODE       = MAX_NODE_DEFAULT,
    parameter int unsigned TIMEOUT_CYCLES = 5_000_000
) (
    input  logic              clk_50M,
    input  logic              reset,
    input  logic [7:0]        rx_msg,
    input  logic              rx_complete,
    input  logic              start_ack,
    output logic [NODE_W-1:0] SP,
    output logic [NODE_W-1:0] EP,
    output logic              start_req,
    output logic              frame_err,
    output logic              byte_drop
);

    localparam int unsigned      CNT_W      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [6:0]       MAX_NODE_7 = 7'(MAX_NODE);

    state_t            r_state;
    logic [3:0]        r_tens;
    logic [NODE_W-1:0] r_sp_pend;
    logic [NODE_W-1:0] r_ep_pend;
    logic [NODE_W-1:0] r_sp;
    logic [NODE_W-1:0] r_ep;
    logic              r_start_req;
    logic              r_frame_err;
    logic              r_byte_drop;
    logic [CNT_W-1:0]  r_cnt;

    logic       w_is_digit;
    logic [3:0] w_digit;
    logic [6:0] w_node;

    ascii_digit_decode u_digit (
        .i_byte     (rx_msg),
        .o_is_digit (w_is_digit),
        .o_value    (w_digit)
    );

    assign w_node = node_value(r_tens, w_digit);

    always_ff @(posedge clk_50M) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_tens      <= '0;
            r_sp_pend   <= '0;
            r_ep_pend   <= '0;
            r_sp        <= '0;
            r_ep        <= '0;
            r_start_req <= 1'b0;
            r_frame_err <= 1'b0;
            r_byte_drop <= 1'b0;
            r_cnt       <= '0;
        end else begin
            r_frame_err <= 1'b0;
            r_byte_drop <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_cnt <= '0;
                    if (rx_complete && rx_msg == ASCII_HASH)
                        r_state <= ST_SP_T;
                end
                ST_REQ: begin
                    r_cnt <= '0;
                    if (rx_complete)
                        r_byte_drop <= 1'b1;
                    if (start_ack) begin
                        r_state     <= ST_IDLE;
                        r_start_req <= 1'b0;
                    end
                end
                default: begin
                    // In-frame states: a byte always beats a simultaneous timeout.
                    if (rx_complete) begin
                        r_cnt <= '0;
                        if (rx_msg == ASCII_HASH) begin
                            r_frame_err <= 1'b1;
                            r_state     <= ST_SP_T;
                        end else begin
                            case (r_state)
                                ST_SP_T, ST_EP_T: begin
                                    if (w_is_digit) begin
                                        r_tens  <= w_digit;
                                        r_state <= (r_state == ST_SP_T) ? ST_SP_U : ST_EP_U;
                                    end else begin
                                        r_frame_err <= 1'b1;
                                        r_state     <= ST_IDLE;
                                    end
                                end
                                ST_SP_U, ST_EP_U: begin
                                    if (!w_is_digit || w_node > MAX_NODE_7) begin
                                        r_frame_err <= 1'b1;
                                        r_state     <= ST_IDLE;
                                    end else if (r_state == ST_SP_U) begin
                                        r_sp_pend <= w_node[NODE_W-1:0];
                                        r_state   <= ST_SEP;
                                    end else begin
                                        r_ep_pend <= w_node[NODE_W-1:0];
                                        r_state   <= ST_TERM;
                                    end
                                end
                                ST_SEP: begin
                                    if (rx_msg == ASCII_COMMA) begin
                                        r_state <= ST_EP_T;
                                    end else begin
                                        r_frame_err <= 1'b1;
                                        r_state     <= ST_IDLE;
                                    end
                                end
                                ST_TERM: begin
                                    if (rx_msg == ASCII_LF) begin
                                        r_sp        <= r_sp_pend;
                                        r_ep        <= r_ep_pend;
                                        r_start_req <= 1'b1;
                                        r_state     <= ST_REQ;
                                    end else if (rx_msg != ASCII_CR) begin
                                        r_frame_err <= 1'b1;
                                        r_state     <= ST_IDLE;
                                    end
                                end
                                default: begin
                                end
                            endcase
                        end
                    end else if (r_cnt == CNT_LAST) begin
                        r_frame_err <= 1'b1;
                        r_state     <= ST_IDLE;
                        r_cnt       <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
            endcase
        end
    end

    assign SP        = r_sp;
    assign EP        = r_ep;
    assign start_req = r_start_req;
    assign frame_err = r_frame_err;
    assign byte_drop = r_byte_drop;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed bench for uart_cmd_parser: frame decode, error paths, resync,
// timeout, byte drop during a pending request, and reset mid-frame.
module tb_uart_cmd_parser;
    import uart_cmd_parser_pkg::*;

    localparam int unsigned TO = 20;

    logic       clk_50M = 1'b0;
    logic       reset   = 1'b1;
    logic [7:0] rx_msg  = '0;
    logic       rx_complete = 1'b0;
    logic       start_ack   = 1'b0;
    logic [4:0] SP;
    logic [4:0] EP;
    logic       start_req;
    logic       frame_err;
    logic       byte_drop;

    int total = 0;
    int bad   = 0;

    always #5 clk_50M = ~clk_50M;

    uart_cmd_parser #(.MAX_NODE(29), .TIMEOUT_CYCLES(TO)) dut (
        .clk_50M     (clk_50M),
        .reset       (reset),
        .rx_msg      (rx_msg),
        .rx_complete (rx_complete),
        .start_ack   (start_ack),
        .SP          (SP),
        .EP          (EP),
        .start_req   (start_req),
        .frame_err   (frame_err),
        .byte_drop   (byte_drop)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the consuming posedge.
    task automatic send_byte(input logic [7:0] b);
        rx_msg      = b;
        rx_complete = 1'b1;
        @(negedge clk_50M);
        rx_complete = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++)
            send_byte(s[i]);
    endtask

    task automatic ack();
        start_ack = 1'b1;
        @(negedge clk_50M);
        start_ack = 1'b0;
    endtask

    initial begin
        int n_err;
        int first;

        // Reset with a strobe present; it must be ignored.
        repeat (2) @(negedge clk_50M);
        rx_msg = 8'h23; rx_complete = 1'b1;
        @(negedge clk_50M);
        rx_complete = 1'b0; reset = 1'b0;
        @(negedge clk_50M);
        check("rst_SP", SP, 0);
        check("rst_EP", EP, 0);
        check("rst_req", start_req, 0);
        check("rst_ferr", frame_err, 0);
        check("rst_drop", byte_drop, 0);
        check("rst_state", 32'(dut.r_state), 32'(ST_IDLE));

        // Good frame and handshake.
        send_str("#03,17");
        check("f1_req_before_lf", start_req, 0);
        send_byte(8'h0A);
        check("f1_req", start_req, 1);
        check("f1_SP", SP, 3);
        check("f1_EP", EP, 17);
        check("f1_ferr", frame_err, 0);
        ack();
        check("f1_req_fall", start_req, 0);
        check("f1_SP_hold", SP, 3);

        // Out-of-range SP on units byte.
        send_str("#3");
        send_byte("1");
        check("f2_ferr", frame_err, 1);
        check("f2_state", 32'(dut.r_state), 32'(ST_IDLE));
        send_byte(",");
        check("f2_ferr_single", frame_err, 0);
        send_str("02");
        send_byte(8'h0A);
        check("f2_ferr_tail", frame_err, 0);
        check("f2_req", start_req, 0);
        check("f2_SP", SP, 3);
        check("f2_EP", EP, 17);

        // Resync on a second '#'.
        send_str("#0");
        send_byte("#");
        check("f3_ferr", frame_err, 1);
        send_byte("0");
        check("f3_ferr_single", frame_err, 0);
        send_str("5,06");
        send_byte(8'h0A);
        check("f3_req", start_req, 1);
        check("f3_SP", SP, 5);
        check("f3_EP", EP, 6);
        ack();

        // Timeout mid-frame.
        send_str("#04,1");
        n_err = 0; first = 0;
        for (int i = 1; i <= 2 * TO; i++) begin
            @(negedge clk_50M);
            if (frame_err === 1'b1) begin
                n_err++;
                if (first == 0) first = i;
            end
        end
        check("to_count", n_err, 1);
        check("to_cycle", first, TO);
        check("to_state", 32'(dut.r_state), 32'(ST_IDLE));
        check("to_SP", SP, 5);
        send_str("#04,12");
        send_byte(8'h0D);
        check("cr_req", start_req, 0);
        check("cr_ferr", frame_err, 0);
        send_byte(8'h0A);
        check("f4_req", start_req, 1);
        check("f4_SP", SP, 4);
        check("f4_EP", EP, 12);

        // Byte drops while the request is pending.
        send_byte("A");
        check("drop1", byte_drop, 1);
        check("drop1_SP", SP, 4);
        check("drop1_EP", EP, 12);
        check("drop1_req", start_req, 1);
        @(negedge clk_50M);
        check("drop1_single", byte_drop, 0);
        start_ack = 1'b1;
        send_byte("B");
        start_ack = 1'b0;
        check("drop2", byte_drop, 1);
        check("drop2_req", start_req, 0);
        check("drop2_state", 32'(dut.r_state), 32'(ST_IDLE));
        @(negedge clk_50M);
        check("drop2_single", byte_drop, 0);

        // Boundaries and per-state errors.
        send_byte("X");
        check("idle_ignore", frame_err, 0);
        send_str("#29,29");
        send_byte(8'h0A);
        check("max_req", start_req, 1);
        check("max_SP", SP, 29);
        check("max_EP", EP, 29);
        ack();
        send_str("#3");
        send_byte("0");
        check("over_max", frame_err, 1);
        send_str("#0");
        send_byte("A");
        check("nondigit", frame_err, 1);
        send_str("#01");
        send_byte(";");
        check("bad_sep", frame_err, 1);
        send_str("#01,02");
        send_byte("X");
        check("bad_term", frame_err, 1);
        check("err_SP_hold", SP, 29);
        check("err_EP_hold", EP, 29);

        // Byte arriving exactly at the timeout boundary wins.
        send_byte("#");
        n_err = 0;
        for (int i = 1; i < TO; i++) begin
            @(negedge clk_50M);
            if (frame_err === 1'b1) n_err++;
        end
        send_byte("0");
        check("edge_ferr", n_err + int'(frame_err), 0);
        check("edge_state", 32'(dut.r_state), 32'(ST_SP_U));

        // Reset mid-frame.
        send_str("#12,");
        reset = 1'b1;
        rx_msg = ","; rx_complete = 1'b1;
        @(negedge clk_50M);
        rx_complete = 1'b0;
        @(negedge clk_50M);
        reset = 1'b0;
        check("mr_SP", SP, 0);
        check("mr_EP", EP, 0);
        check("mr_req", start_req, 0);
        check("mr_ferr", frame_err, 0);
        check("mr_drop", byte_drop, 0);
        send_byte(",");
        check("mr_ferr1", frame_err, 0);
        send_byte("3");
        check("mr_ferr2", frame_err, 0);
        send_byte(8'h0A);
        check("mr_ferr3", frame_err, 0);
        check("mr_req_after", start_req, 0);
        @(negedge clk_50M);
        check("mr_req_later", start_req, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
